seq_divider_8by4: RTL and testbench

- Iterative restoring binary divider. It is the inverse companion of the team's 4-bit combinational multiplier: it takes an 8-bit dividend (a product) and a 4-bit divisor, and returns the quotient and remainder.
- It produces one quotient bit per clock, uses a start/done handshake, and latches its operands.
- It is a reusable arithmetic block in the same design library as the multiplier, so that p/b recovers a.

---
 rtl/seq_divider_8by4.sv | 139 +++++++++++++
 tb/tb_seq_divider_8by4.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8by4.sv
// Iterative restoring divider: unsigned dividend / divisor, one quotient bit per clock,
// start/done handshake with operands latched on accept and a divide-by-zero flag.
module seq_divider_8by4 #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz
);

    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam int unsigned PR_W  = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [PR_W-1:0]       pr_q, pr_d;
    logic [DIVIDEND_W-2:0] qsr_q, qsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dbz_q, dbz_d;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    logic [PR_W:0]         pr_sh;
    logic [PR_W:0]         trial;
    logic                  qbit;
    logic [PR_W-1:0]       pr_new;
    logic [DIVIDEND_W-1:0] qsr_full;

    always_comb begin
        pr_sh    = {pr_q, dvd_q[DIVIDEND_W-1]};
        trial    = pr_sh - {2'b00, dvs_q};
        qbit     = ~trial[PR_W];
        pr_new   = qbit ? trial[PR_W-1:0] : pr_sh[PR_W-1:0];
        qsr_full = {qsr_q, qbit};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        pr_d        = pr_q;
        qsr_d       = qsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = '1;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        pr_d    = '0;
                        qsr_d   = '0;
                        cnt_d   = CNT_W'(DIVIDEND_W - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                pr_d  = pr_new;
                qsr_d = qsr_full[DIVIDEND_W-2:0];
                if (cnt_q == '0) begin
                    quotient_d  = qsr_full;
                    remainder_d = pr_new[DIVISOR_W-1:0];
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            pr_q        <= '0;
            qsr_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            pr_q        <= pr_d;
            qsr_q       <= qsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Directed bench for seq_divider_8by4: table of divisions plus hand-written
// sequences for start-while-busy and mid-operation reset.
module tb_seq_divider_8by4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    int n_total = 0;
    int n_pass  = 0;

    seq_divider_8by4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Pulse start for one accept edge, then count further edges until done is seen
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int edges);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    vec_t vecs[11];

    initial begin
        int edges;
        int done_cnt;
        vecs[0]  = '{8'd200, 4'd13, 8'd15,  4'd5,  1'b0};
        vecs[1]  = '{8'hC3,  4'd13, 8'd15,  4'd0,  1'b0};
        vecs[2]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        vecs[3]  = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0};
        vecs[4]  = '{8'd100, 4'd0,  8'hFF,  4'hF,  1'b1};
        vecs[5]  = '{8'd50,  4'd7,  8'd7,   4'd1,  1'b0};
        vecs[6]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
        vecs[7]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        vecs[8]  = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0};
        vecs[9]  = '{8'd0,   4'd0,  8'hFF,  4'hF,  1'b1};
        vecs[10] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};

        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_quotient",  int'(quotient),  0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_busy",      int'(busy),      0);
        chk("reset_done",      int'(done),      0);
        chk("reset_dbz",       int'(dbz),       0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, edges);
            chk($sformatf("v%0d_latency", i), edges, vecs[i].z ? 0 : 8);
            chk($sformatf("v%0d_done", i), int'(done), 1);
            chk($sformatf("v%0d_quotient", i), int'(quotient), int'(vecs[i].q));
            chk($sformatf("v%0d_remainder", i), int'(remainder), int'(vecs[i].r));
            chk($sformatf("v%0d_dbz", i), int'(dbz), int'(vecs[i].z));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
            chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
            chk($sformatf("v%0d_hold_quotient", i), int'(quotient), int'(vecs[i].q));
        end

        // start with new operands while in CALC must be ignored
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd13;
        start    = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_accept", int'(busy), 1);
        dividend = 8'd9;
        divisor  = 4'd3;
        edges    = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        chk("ignore_latency",   edges, 8);
        chk("ignore_quotient",  int'(quotient),  15);
        chk("ignore_remainder", int'(remainder), 5);
        done_cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("ignore_single_done", done_cnt, 0);
        chk("ignore_idle_after", int'(busy), 0);

        // reset in the middle of a calculation aborts without done
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd13;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_quotient",  int'(quotient),  0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_busy",      int'(busy),      0);
        chk("abort_done",      int'(done),      0);
        done_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        run_op(8'd45, 4'd4, edges);
        chk("after_abort_latency",   edges, 8);
        chk("after_abort_quotient",  int'(quotient),  11);
        chk("after_abort_remainder", int'(remainder), 1);
        chk("after_abort_dbz",       int'(dbz),       0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
